// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, write-back select encodings and
// the write-back data mux used by the pipeline stages.
package cpu_pkg;
    localparam int DATA_W = 8;
    localparam int RA_W   = 2;
    localparam int NREG   = 4;
    localparam int CNT_W  = 16;

    // wb_wb_sel encoding
    localparam logic WB_SEL_LINK  = 1'b0;
    localparam logic WB_SEL_DATA  = 1'b1;
    // wb_data_sel encoding
    localparam logic DATA_SEL_ALU = 1'b0;
    localparam logic DATA_SEL_DM  = 1'b1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [RA_W-1:0]   ra_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Selects the value committed to the register file.
    function automatic data_t wb_mux(input logic  wb_sel,
                                     input logic  data_sel,
                                     input data_t dm,
                                     input data_t alu,
                                     input data_t lnk);
        if (wb_sel == WB_SEL_LINK) begin
            return lnk;
        end
        return (data_sel == DATA_SEL_DM) ? dm : alu;
    endfunction
endpackage

// File: rtl/pipeline_wb_if.sv
// Write-back stage bus: MEM/WB register fields in, register-file read
// ports, forwarding path and retire count out.
interface pipeline_wb_if;
    import cpu_pkg::*;

    data_t DM;
    data_t ALU_ea;
    data_t link_val;
    ra_t   ra;
    logic  wb_wb_sel;
    logic  wb_data_sel;
    logic  wb_reg_en;
    logic  wb_valid;
    ra_t   rs1;
    ra_t   rs2;
    data_t rd1;
    data_t rd2;
    data_t fwd_data;
    ra_t   fwd_ra;
    logic  fwd_en;
    cnt_t  retired;

    modport master (
        output DM, ALU_ea, link_val, ra, wb_wb_sel, wb_data_sel,
               wb_reg_en, wb_valid, rs1, rs2,
        input  rd1, rd2, fwd_data, fwd_ra, fwd_en, retired
    );

    modport slave (
        input  DM, ALU_ea, link_val, ra, wb_wb_sel, wb_data_sel,
               wb_reg_en, wb_valid, rs1, rs2,
        output rd1, rd2, fwd_data, fwd_ra, fwd_en, retired
    );
endinterface

// File: rtl/reg_file_4x8.sv
// Four-entry, 8-bit register file with two combinational read ports and a
// write-through bypass so a reader sees the value being written this cycle.
module reg_file_4x8
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  i_rst_n,
    input  logic  i_we,
    input  ra_t   i_wa,
    input  data_t i_wd,
    input  ra_t   i_rs1,
    input  ra_t   i_rs2,
    output data_t o_rd1,
    output data_t o_rd2
);
    data_t r_regs [NREG];

    // Register array: cleared by reset, written on the edge when enabled.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Read ports with bypass; forced to zero while reset is held so a
    // pending write cannot leak through.
    always_comb begin
        o_rd1 = r_regs[i_rs1];
        o_rd2 = r_regs[i_rs2];
        if (i_we && (i_rs1 == i_wa)) o_rd1 = i_wd;
        if (i_we && (i_rs2 == i_wa)) o_rd2 = i_wd;
        if (!i_rst_n) begin
            o_rd1 = '0;
            o_rd2 = '0;
        end
    end
endmodule

// File: rtl/pipeline_wb.sv
// Write-back stage: selects the commit value, drives the register file,
// keeps a registered copy of the last commit for EX forwarding, and counts
// retired instructions (bubbles excluded, non-writing instructions included).
module pipeline_wb
    import cpu_pkg::*;
(
    input logic         clk,
    input logic         rst,
    pipeline_wb_if.slave bus
);
    data_t w_wdata;
    logic  w_we;
    data_t r_fwd_data;
    ra_t   r_fwd_ra;
    logic  r_fwd_en;
    cnt_t  r_retired;

    assign w_wdata = wb_mux(bus.wb_wb_sel, bus.wb_data_sel,
                            bus.DM, bus.ALU_ea, bus.link_val);
    assign w_we    = bus.wb_reg_en & bus.wb_valid;

    reg_file_4x8 u_rf (
        .clk     (clk),
        .i_rst_n (rst),
        .i_we    (w_we),
        .i_wa    (bus.ra),
        .i_wd    (w_wdata),
        .i_rs1   (bus.rs1),
        .i_rs2   (bus.rs2),
        .o_rd1   (bus.rd1),
        .o_rd2   (bus.rd2)
    );

    // Forwarding register: valid flag tracks every cycle, payload holds
    // the most recent committed write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_en   <= 1'b0;
            r_fwd_data <= '0;
            r_fwd_ra   <= '0;
        end else begin
            r_fwd_en <= w_we;
            if (w_we) begin
                r_fwd_data <= w_wdata;
                r_fwd_ra   <= bus.ra;
            end
        end
    end

    // Retire counter; wraps naturally at full scale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retired <= '0;
        end else if (bus.wb_valid) begin
            r_retired <= r_retired + cnt_t'(1);
        end
    end

    assign bus.fwd_data = r_fwd_data;
    assign bus.fwd_ra   = r_fwd_ra;
    assign bus.fwd_en   = r_fwd_en;
    assign bus.retired  = r_retired;
endmodule
